instr_register_pipe: RTL and testbench

Parametrised, pipelined successor to the lab instruction register. It captures an opcode and two signed operands on a write port, computes the result in a registered ALU stage, and stores the full instruction word in a DEPTH-entry register stack. Contents are returned through a registered read port with per-entry valid tracking and write-to-read forwarding. It sits between the stimulus/driver side and the result consumer and is the DUT for the class-based testbench labs.

---
 rtl/instr_register_pkg.sv | 25 ++
 rtl/instr_alu.sv | 66 ++++++
 rtl/instr_register_pipe.sv | 133 +++++++++++++
 tb/tb_instr_register_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_register_pkg                                            |
// | Description : Opcode encoding and default sizing for instr_register_pipe.  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package instr_register_pkg;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    localparam int c_OP_W  = 32;
    localparam int c_RES_W = 2 * c_OP_W;
    localparam int c_DEPTH = 32;

endpackage : instr_register_pkg
`default_nettype wire

// File: rtl/instr_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_alu                                                     |
// | Description : Combinational signed ALU; INSTR_REG_SAT_EN clamps ADD/SUB/    |
// |               MULT results to the signed OP_W range.                        |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int OP_W  = c_OP_W,
    parameter int RES_W = c_RES_W
) (
    input  opcode_t                  opc,
    input  logic signed [OP_W-1:0]   a,
    input  logic signed [OP_W-1:0]   b,
    output logic signed [RES_W-1:0]  res,
    output logic                     div_err
);

    logic signed [RES_W-1:0] w_a;
    logic signed [RES_W-1:0] w_b;
    logic signed [RES_W-1:0] w_arith;
    logic                    w_is_arith;
    logic                    w_b_zero;

    assign w_a      = {{(RES_W-OP_W){a[OP_W-1]}}, a};
    assign w_b      = {{(RES_W-OP_W){b[OP_W-1]}}, b};
    assign w_b_zero = (b == '0);

`ifdef INSTR_REG_SAT_EN
    logic signed [RES_W-1:0] w_max;
    logic signed [RES_W-1:0] w_min;
    assign w_max = {{(RES_W-OP_W+1){1'b0}}, {(OP_W-1){1'b1}}};
    assign w_min = {{(RES_W-OP_W+1){1'b1}}, {(OP_W-1){1'b0}}};
`endif

    always_comb begin
        w_arith    = '0;
        w_is_arith = 1'b0;
        res        = '0;
        div_err    = 1'b0;
        case (opc)
            ZERO:  res = '0;
            PASSA: res = w_a;
            PASSB: res = w_b;
            ADD:   begin w_arith = w_a + w_b; w_is_arith = 1'b1; end
            SUB:   begin w_arith = w_a - w_b; w_is_arith = 1'b1; end
            MULT:  begin w_arith = w_a * w_b; w_is_arith = 1'b1; end
            DIV:   if (w_b_zero) div_err = 1'b1; else res = w_a / w_b;
            MOD:   if (w_b_zero) div_err = 1'b1; else res = w_a % w_b;
            default: res = '0;
        endcase
        if (w_is_arith) begin
`ifdef INSTR_REG_SAT_EN
            if (w_arith > w_max)      res = w_max;
            else if (w_arith < w_min) res = w_min;
            else                      res = w_arith;
`else
            res = w_arith;
`endif
        end
    end

endmodule : instr_alu
`default_nettype wire

// File: rtl/instr_register_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_register_pipe                                           |
// | Description : Pipelined instruction register stack with registered ALU,    |
// |               per-entry valid bits and write-to-read forwarding.           |
// |               INSTR_REG_SAT_EN enables ALU saturation (see instr_alu).      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module instr_register_pipe
    import instr_register_pkg::*;
#(
    parameter  int OP_W   = c_OP_W,
    parameter  int RES_W  = c_RES_W,
    parameter  int DEPTH  = c_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int WORD_W = 3 + 2*OP_W + RES_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_en,
    input  logic [ADDR_W-1:0]        write_pointer,
    input  opcode_t                  opcode,
    input  logic signed [OP_W-1:0]   operand_a,
    input  logic signed [OP_W-1:0]   operand_b,
    input  logic                     read_en,
    input  logic [ADDR_W-1:0]        read_pointer,
    output logic [WORD_W-1:0]        instruction_word,
    output logic                     rd_valid,
    output logic                     rd_hit,
    output logic                     div_err
);

    typedef struct packed {
        opcode_t                 opc;
        logic signed [OP_W-1:0]  op_a;
        logic signed [OP_W-1:0]  op_b;
        logic signed [RES_W-1:0] res;
    } instruction_t;

    logic                    r_s1_vld;
    logic [ADDR_W-1:0]       r_s1_addr;
    opcode_t                 r_s1_opc;
    logic signed [OP_W-1:0]  r_s1_a;
    logic signed [OP_W-1:0]  r_s1_b;

    logic [DEPTH-1:0]        r_valid;
    instruction_t            r_mem [DEPTH];

    instruction_t            r_rd_word;
    logic                    r_rd_valid;
    logic                    r_rd_hit;

    logic signed [RES_W-1:0] w_res;
    logic                    w_div_err;
    instruction_t            w_commit;
    logic                    w_fwd;

    instr_alu #(
        .OP_W  (OP_W),
        .RES_W (RES_W)
    ) u_alu (
        .opc     (r_s1_opc),
        .a       (r_s1_a),
        .b       (r_s1_b),
        .res     (w_res),
        .div_err (w_div_err)
    );

    assign w_commit = '{opc: r_s1_opc, op_a: r_s1_a, op_b: r_s1_b, res: w_res};
    // A read landing in the commit cycle of the same entry must see the new word.
    assign w_fwd    = r_s1_vld && (r_s1_addr == read_pointer);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_addr <= '0;
            r_s1_opc  <= ZERO;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
        end else begin
            r_s1_vld <= load_en;
            if (load_en) begin
                r_s1_addr <= write_pointer;
                r_s1_opc  <= opcode;
                r_s1_a    <= operand_a;
                r_s1_b    <= operand_b;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (r_s1_vld) begin
            r_valid[r_s1_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_s1_vld) begin
            r_mem[r_s1_addr] <= w_commit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
            r_rd_hit   <= 1'b0;
            r_rd_word  <= '0;
        end else if (read_en) begin
            r_rd_valid <= 1'b1;
            if (w_fwd) begin
                r_rd_word <= w_commit;
                r_rd_hit  <= 1'b1;
            end else if (r_valid[read_pointer]) begin
                r_rd_word <= r_mem[read_pointer];
                r_rd_hit  <= 1'b1;
            end else begin
                r_rd_word <= '0;
                r_rd_hit  <= 1'b0;
            end
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign instruction_word = r_rd_word;
    assign rd_valid         = r_rd_valid;
    assign rd_hit           = r_rd_hit;
    assign div_err          = r_s1_vld & w_div_err;

endmodule : instr_register_pipe
`default_nettype wire

// File: tb/tb_instr_register_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_register_pipe                                        |
// | Description : Randomised scoreboard bench for instr_register_pipe.         |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_instr_register_pipe;
    import instr_register_pkg::*;

    localparam int OP_W   = 8;
    localparam int RES_W  = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int WORD_W = 3 + 2*OP_W + RES_W;

    logic                   clk;
    logic                   reset_n;
    logic                   load_en;
    logic [ADDR_W-1:0]      write_pointer;
    opcode_t                opcode;
    logic signed [OP_W-1:0] operand_a;
    logic signed [OP_W-1:0] operand_b;
    logic                   read_en;
    logic [ADDR_W-1:0]      read_pointer;
    logic [WORD_W-1:0]      instruction_word;
    logic                   rd_valid;
    logic                   rd_hit;
    logic                   div_err;

    instr_register_pipe #(
        .OP_W  (OP_W),
        .RES_W (RES_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .load_en          (load_en),
        .write_pointer    (write_pointer),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .read_en          (read_en),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .rd_valid         (rd_valid),
        .rd_hit           (rd_hit),
        .div_err          (div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WORD_W-1:0] word;
        logic              hit;
        int                cyc;
    } exp_t;

    exp_t              exp_q[$];
    logic [WORD_W-1:0] m_word  [DEPTH];
    logic              m_valid [DEPTH];
    int                errors = 0;
    int                checks = 0;
    int                cyc    = 0;
    logic              exp_div = 1'b0;
    logic              pending_div = 1'b0;
    logic [WORD_W-1:0] last_word = '0;
    logic              last_hit  = 1'b0;
    bit                mon_en    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference result from the arithmetic rules, in 64-bit integers.
    function automatic logic [RES_W-1:0] model_res(input opcode_t op,
                                                   input logic signed [OP_W-1:0] a,
                                                   input logic signed [OP_W-1:0] b);
        longint la = a;
        longint lb = b;
        longint r  = 0;
        longint lo = -(64'sd1 <<< (OP_W-1));
        longint hi = (64'sd1 <<< (OP_W-1)) - 1;
        case (op)
            PASSA: r = la;
            PASSB: r = lb;
            ADD:   r = la + lb;
            SUB:   r = la - lb;
            MULT:  r = la * lb;
            DIV:   r = (lb == 0) ? 0 : la / lb;
            MOD:   r = (lb == 0) ? 0 : la % lb;
            default: r = 0;
        endcase
`ifdef INSTR_REG_SAT_EN
        if (op == ADD || op == SUB || op == MULT) begin
            if (r > hi) r = hi;
            if (r < lo) r = lo;
        end
`else
        if (lo > hi) r = 0;
`endif
        return r[RES_W-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("div_err", 64'(div_err), 64'(exp_div));
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_valid_unexpected", 64'(rd_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_cycle", 64'(cyc), 64'(e.cyc));
                    check("rd_word", 64'(instruction_word), 64'(e.word));
                    check("rd_hit", 64'(rd_hit), 64'(e.hit));
                    last_word = e.word;
                    last_hit  = e.hit;
                end
            end else begin
                check("hold_word", 64'(instruction_word), 64'(last_word));
                check("hold_hit", 64'(rd_hit), 64'(last_hit));
            end
        end
    end

    // One bus cycle: a read sees every write issued in earlier cycles only.
    task automatic step(input logic ld, input logic [ADDR_W-1:0] wp, input opcode_t op,
                        input logic signed [OP_W-1:0] a, input logic signed [OP_W-1:0] b,
                        input logic rd, input logic [ADDR_W-1:0] rp);
        @(posedge clk);
        #1;
        exp_div       = pending_div;
        load_en       = ld;
        write_pointer = wp;
        opcode        = op;
        operand_a     = a;
        operand_b     = b;
        read_en       = rd;
        read_pointer  = rp;
        if (rd) exp_q.push_back('{word: (m_valid[rp] ? m_word[rp] : '0), hit: m_valid[rp], cyc: cyc + 1});
        if (ld) begin
            m_word[wp]  = {op, a, b, model_res(op, a, b)};
            m_valid[wp] = 1'b1;
        end
        pending_div = ld && (op == DIV || op == MOD) && (b == 0);
    endtask

    task automatic idle();
        step(1'b0, '0, ZERO, '0, '0, 1'b0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_word"},  64'(instruction_word), 64'd0);
        check({tag, "_valid"}, 64'(rd_valid), 64'd0);
        check({tag, "_hit"},   64'(rd_hit), 64'd0);
        check({tag, "_div"},   64'(div_err), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; load_en = 1'b0; write_pointer = '0; opcode = ZERO;
        operand_a = '0; operand_b = '0; read_en = 1'b0; read_pointer = '0;
        for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 1'b0; m_word[i] = '0; end
        @(posedge clk); #2;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, ZERO, '0, '0, 1'b1, ADDR_W'(i));

        step(1'b1, 3'd3, MULT, -8'sd7, 8'sd6, 1'b0, '0);
        idle();
        step(1'b0, '0, ZERO, '0, '0, 1'b1, 3'd3);

        step(1'b1, 3'd5, ADD, 8'sd9, 8'sd4, 1'b1, 3'd5);
        step(1'b0, '0, ZERO, '0, '0, 1'b1, 3'd5);

        step(1'b1, 3'd1, DIV, 8'sd15, 8'sd0, 1'b0, '0);
        step(1'b1, 3'd2, DIV, -8'sd7, 8'sd2, 1'b0, '0);
        step(1'b1, 3'd4, MOD, -8'sd7, 8'sd2, 1'b1, 3'd1);
        step(1'b1, 3'd6, ADD, 8'sd100, 8'sd100, 1'b1, 3'd2);
        step(1'b1, 3'd7, SUB, -8'sd100, 8'sd100, 1'b1, 3'd4);
        step(1'b1, 3'd7, SUB, -8'sd100, 8'sd100, 1'b1, 3'd6);
        step(1'b0, '0, ZERO, '0, '0, 1'b1, 3'd7);
        repeat (3) idle();

        for (int n = 0; n < 400; n++) begin
            logic signed [OP_W-1:0] rb;
            rb = ($urandom_range(0, 5) == 0) ? '0 : OP_W'($urandom);
            step(1'($urandom_range(0, 1)), ADDR_W'($urandom), opcode_t'($urandom_range(0, 7)),
                 OP_W'($urandom), rb, 1'($urandom_range(0, 2) != 0), ADDR_W'($urandom));
        end
        repeat (2) idle();

        step(1'b1, 3'd2, ADD, 8'sd1, 8'sd1, 1'b0, '0);
        @(posedge clk); #1;
        load_en = 1'b0; read_en = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        exp_q.delete();
        pending_div = 1'b0; exp_div = 1'b0;
        last_word = '0; last_hit = 1'b0;
        @(posedge clk); #3;
        reset_n = 1'b1;
        step(1'b0, '0, ZERO, '0, '0, 1'b1, 3'd2);
        step(1'b1, 3'd2, PASSB, 8'sd3, -8'sd5, 1'b0, '0);
        step(1'b0, '0, ZERO, '0, '0, 1'b1, 3'd2);
        repeat (3) idle();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_instr_register_pipe
`default_nettype wire
